// File: rtl/apu_timing_pkg.sv
// Shared timing constants for the APU frame scheduler.
// Step masks use bit n for sequencer step n; the constants are the
// default divisors and increments for a 12.288 MHz ac97_bitclk.
package apu_timing_pkg;

  // Steps on which each channel timing event fires
  localparam logic [7:0] LEN_STEP_MASK   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEP_MASK = 8'b0100_0100;
  localparam logic [7:0] ENV_STEP_MASK   = 8'b1000_0000;

  // 12.288 MHz / 512 Hz frame-sequencer rate
  localparam int FRAME_DIV = 24000;

  // Modulo accumulators: 12.288 MHz * INC / MOD gives the strobe rate
  localparam int NCO_MOD   = 375;
  localparam int NCO_INC12 = 4;
  localparam int NCO_INC3  = 2;

endpackage

// File: rtl/apu_nco_tick.sv
// Modulo accumulator that emits a one-cycle tick whenever the running sum
// crosses MOD, giving an average rate of f_clk * INC / MOD with no drift.
// Only reset clears the accumulator; nothing else disturbs its phase.
module apu_nco_tick #(
  parameter int MOD = 375,
  parameter int INC = 4
) (
  input  logic ac97_bitclk,
  input  logic reset,
  output logic tick
);

  localparam int W = $clog2(MOD + INC);

  logic [W-1:0] acc;
  logic [W-1:0] sum;

  // Candidate next value before the modulo fold
  always_comb begin
    sum = acc + W'(INC);
  end

  // Fold the sum back into range and flag the crossing as a tick
  always_ff @(posedge ac97_bitclk) begin
    if (reset) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= W'(MOD)) begin
      acc  <= sum - W'(MOD);
      tick <= 1'b1;
    end else begin
      acc  <= sum;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/apu_frame_scheduler.sv
// Single-clock timing scheduler for the sound channels. Every channel
// timing event is a one-cycle enable pulse in the ac97_bitclk domain.
// Define APU_FRAME_SCHED_FASTSIM_EN to divide the frame divisor by 1000
// so simulations reach envelope steps quickly; leave it undefined for
// synthesis.
module apu_frame_scheduler
  import apu_timing_pkg::LEN_STEP_MASK,
         apu_timing_pkg::SWEEP_STEP_MASK,
         apu_timing_pkg::ENV_STEP_MASK;
#(
  parameter int FRAME_DIV = apu_timing_pkg::FRAME_DIV,
  parameter int NCO_MOD   = apu_timing_pkg::NCO_MOD,
  parameter int NCO_INC12 = apu_timing_pkg::NCO_INC12,
  parameter int NCO_INC3  = apu_timing_pkg::NCO_INC3
) (
  input  logic       ac97_bitclk,
  input  logic       reset,
  input  logic       master_sound_enable,
  input  logic       seq_resync,
  output logic       frame_tick,
  output logic       length_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic       freq12_tick,
  output logic       freq3_tick,
  output logic [2:0] step
);

`ifdef APU_FRAME_SCHED_FASTSIM_EN
  localparam int EFF_DIV = FRAME_DIV / 1000;
`else
  localparam int EFF_DIV = FRAME_DIV;
`endif

  localparam int PW = (EFF_DIV > 1) ? $clog2(EFF_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(EFF_DIV - 1);

  logic [PW-1:0] prescaler;

  // Frame sequencer: prescaler wrap executes the current step and advances it;
  // a disabled master or a resync holds/restarts the sequence at step 0
  always_ff @(posedge ac97_bitclk) begin
    if (reset || !master_sound_enable || seq_resync) begin
      prescaler   <= '0;
      step        <= 3'd0;
      frame_tick  <= 1'b0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end else if (prescaler == PRESC_LAST) begin
      prescaler   <= '0;
      step        <= step + 3'd1;
      frame_tick  <= 1'b1;
      length_tick <= LEN_STEP_MASK[step];
      sweep_tick  <= SWEEP_STEP_MASK[step];
      env_tick    <= ENV_STEP_MASK[step];
    end else begin
      prescaler   <= prescaler + PW'(1);
      frame_tick  <= 1'b0;
      length_tick <= 1'b0;
      sweep_tick  <= 1'b0;
      env_tick    <= 1'b0;
    end
  end

  apu_nco_tick #(
    .MOD (NCO_MOD),
    .INC (NCO_INC12)
  ) u_nco12 (
    .ac97_bitclk (ac97_bitclk),
    .reset       (reset),
    .tick        (freq12_tick)
  );

  apu_nco_tick #(
    .MOD (NCO_MOD),
    .INC (NCO_INC3)
  ) u_nco3 (
    .ac97_bitclk (ac97_bitclk),
    .reset       (reset),
    .tick        (freq3_tick)
  );

endmodule
